// File: rtl/cpu_pkg.sv
// Shared encodings for the 65C02 address datapath.
// Holds the ADL base/addend select codes, ADH op codes and fixed page constants.
package cpu_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ABL_SEL_W = 2;
    localparam int unsigned ABH_OP_W  = 3;

    // ADL base select, abl_op[1:0]
    localparam logic [ABL_SEL_W-1:0] ABL_BASE_ABL = 2'b00;
    localparam logic [ABL_SEL_W-1:0] ABL_BASE_PCL = 2'b01;
    localparam logic [ABL_SEL_W-1:0] ABL_BASE_DB  = 2'b10;
    localparam logic [ABL_SEL_W-1:0] ABL_BASE_AHL = 2'b11;

    // ADL addend select, abl_op[3:2]
    localparam logic [ABL_SEL_W-1:0] ABL_ADD_ZERO     = 2'b00;
    localparam logic [ABL_SEL_W-1:0] ABL_ADD_REG      = 2'b01;
    localparam logic [ABL_SEL_W-1:0] ABL_ADD_REG_ONLY = 2'b10;
    localparam logic [ABL_SEL_W-1:0] ABL_ADD_DEC      = 2'b11;

    // ADH operation, abh_op
    localparam logic [ABH_OP_W-1:0] ABH_OP_ABH    = 3'b000;
    localparam logic [ABH_OP_W-1:0] ABH_OP_ABH_C  = 3'b001;
    localparam logic [ABH_OP_W-1:0] ABH_OP_PCH    = 3'b010;
    localparam logic [ABH_OP_W-1:0] ABH_OP_PCH_C  = 3'b011;
    localparam logic [ABH_OP_W-1:0] ABH_OP_DB     = 3'b100;
    localparam logic [ABH_OP_W-1:0] ABH_OP_DB_C   = 3'b101;
    localparam logic [ABH_OP_W-1:0] ABH_OP_ZERO   = 3'b110;
    localparam logic [ABH_OP_W-1:0] ABH_OP_STACK  = 3'b111;

    localparam logic [BYTE_W-1:0] VEC_PAGE   = 8'hFF;
    localparam logic [BYTE_W-1:0] STACK_PAGE = 8'h01;

endpackage

// File: rtl/pc_reg.sv
// Program counter PCH:PCL with increment carry chain.
// Ports: i_ld_pc/i_inc_pc select load/increment, i_ad_lo/i_ad_hi current address,
//        o_pcl/o_pch registered PC, o_pcl_co_c combinational PCL increment carry.
module pc_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_ld_pc,
    input  logic              i_inc_pc,
    input  logic [BYTE_W-1:0] i_ad_lo,
    input  logic [BYTE_W-1:0] i_ad_hi,
    output logic [BYTE_W-1:0] o_pcl,
    output logic [BYTE_W-1:0] o_pch,
    output logic              o_pcl_co_c
);

    logic [BYTE_W-1:0] r_pcl;
    logic [BYTE_W-1:0] r_pch;
    logic [BYTE_W-1:0] w_src_lo;
    logic [BYTE_W-1:0] w_src_hi;

    assign w_src_lo   = i_ld_pc ? i_ad_lo : r_pcl;
    assign w_src_hi   = i_ld_pc ? i_ad_hi : r_pch;
    assign o_pcl_co_c = i_inc_pc & (w_src_lo == 8'hFF);

    // Low byte increments; its carry ripples into the high byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcl <= '0;
            r_pch <= '0;
        end else begin
            r_pcl <= w_src_lo + BYTE_W'(i_inc_pc);
            r_pch <= w_src_hi + BYTE_W'(o_pcl_co_c);
        end
    end

    assign o_pcl = r_pcl;
    assign o_pch = r_pch;

endmodule

// File: rtl/addr_bus_unit.sv
// 16-bit address generator for the 65C02 microcoded core.
// Builds the combinational address {ADH, ADL} from PC, DB, a register-file byte
// and the held address ABH:ABL; owns PC, ABH:ABL and the AHL latch.
// Ports: abl_op/abl_ci/abh_op/abh_ff select the address; ld_ahl, ld_pc, inc_pc
//        update state; DB/REG data inputs; ADL/ADH/abl_co/pcl_co combinational;
//        PCL/PCH registered.
// Build option: ABL_DEC_EN makes addend code 11 add 8'hFF (decrement).
module addr_bus_unit
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           abl_op,
    input  logic                 abl_ci,
    input  logic [ABH_OP_W-1:0]  abh_op,
    input  logic                 abh_ff,
    input  logic                 ld_ahl,
    input  logic                 ld_pc,
    input  logic                 inc_pc,
    input  logic [BYTE_W-1:0]    DB,
    input  logic [BYTE_W-1:0]    REG,
    output logic [BYTE_W-1:0]    ADL,
    output logic [BYTE_W-1:0]    ADH,
    output logic                 abl_co,
    output logic [BYTE_W-1:0]    PCL,
    output logic [BYTE_W-1:0]    PCH,
    output logic                 pcl_co
);

    logic [BYTE_W-1:0] r_abl;
    logic [BYTE_W-1:0] r_abh;
    logic [BYTE_W-1:0] r_ahl;
    logic [BYTE_W-1:0] w_base;
    logic [BYTE_W-1:0] w_addend;
    logic [BYTE_W:0]   w_sum;
    logic [BYTE_W-1:0] w_adh;

    // ADL base and addend selection
    always_comb begin
        w_base   = '0;
        w_addend = '0;
        case (abl_op[1:0])
            ABL_BASE_ABL: w_base = r_abl;
            ABL_BASE_PCL: w_base = PCL;
            ABL_BASE_DB:  w_base = DB;
            ABL_BASE_AHL: w_base = r_ahl;
            default:      w_base = '0;
        endcase
        case (abl_op[3:2])
            ABL_ADD_ZERO:     w_addend = '0;
            ABL_ADD_REG:      w_addend = REG;
            ABL_ADD_REG_ONLY: begin
                w_base   = '0;
                w_addend = REG;
            end
            ABL_ADD_DEC: begin
`ifdef ABL_DEC_EN
                w_addend = 8'hFF;
`else
                w_addend = '0;
`endif
            end
            default:          w_addend = '0;
        endcase
    end

    assign w_sum  = (BYTE_W+1)'(w_base) + (BYTE_W+1)'(w_addend) + (BYTE_W+1)'(abl_ci);
    assign ADL    = w_sum[BYTE_W-1:0];
    assign abl_co = w_sum[BYTE_W];

    // ADH selection; carry-in forms wrap modulo 256
    always_comb begin
        w_adh = '0;
        case (abh_op)
            ABH_OP_ABH:   w_adh = r_abh;
            ABH_OP_ABH_C: w_adh = r_abh + BYTE_W'(abl_co);
            ABH_OP_PCH:   w_adh = PCH;
            ABH_OP_PCH_C: w_adh = PCH + BYTE_W'(abl_co);
            ABH_OP_DB:    w_adh = DB;
            ABH_OP_DB_C:  w_adh = DB + BYTE_W'(abl_co);
            ABH_OP_ZERO:  w_adh = '0;
            ABH_OP_STACK: w_adh = STACK_PAGE;
            default:      w_adh = '0;
        endcase
    end

    assign ADH = abh_ff ? VEC_PAGE : w_adh;

    // Held address tracks the bus every cycle; AHL latches DB on demand
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_abl <= '0;
            r_abh <= '0;
            r_ahl <= '0;
        end else begin
            r_abl <= ADL;
            r_abh <= ADH;
            if (ld_ahl) begin
                r_ahl <= DB;
            end
        end
    end

    pc_reg u_pc_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_ld_pc    (ld_pc),
        .i_inc_pc   (inc_pc),
        .i_ad_lo    (ADL),
        .i_ad_hi    (ADH),
        .o_pcl      (PCL),
        .o_pch      (PCH),
        .o_pcl_co_c (pcl_co)
    );

endmodule

// File: tb/tb_addr_bus_unit.sv
// Self-checking bench for addr_bus_unit: directed scenarios plus random ops
// compared against an integer-arithmetic reference model of the address unit.
`timescale 1ns/1ps
module tb_addr_bus_unit;

    logic       clk;
    logic       reset_n;
    logic [3:0] abl_op;
    logic       abl_ci;
    logic [2:0] abh_op;
    logic       abh_ff;
    logic       ld_ahl;
    logic       ld_pc;
    logic       inc_pc;
    logic [7:0] DB;
    logic [7:0] REG;
    logic [7:0] ADL;
    logic [7:0] ADH;
    logic       abl_co;
    logic [7:0] PCL;
    logic [7:0] PCH;
    logic       pcl_co;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_abl, m_abh, m_ahl, m_pc;
    int e_adl, e_co, e_adh, e_pcl_co, e_pc_next;

    addr_bus_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .abl_op  (abl_op),
        .abl_ci  (abl_ci),
        .abh_op  (abh_op),
        .abh_ff  (abh_ff),
        .ld_ahl  (ld_ahl),
        .ld_pc   (ld_pc),
        .inc_pc  (inc_pc),
        .DB      (DB),
        .REG     (REG),
        .ADL     (ADL),
        .ADH     (ADH),
        .abl_co  (abl_co),
        .PCL     (PCL),
        .PCH     (PCH),
        .pcl_co  (pcl_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected combinational results from the current inputs and model state
    task automatic model_comb();
        int base, addend, sum, src;
        base = 0;
        case (int'(abl_op[1:0]))
            0: base = m_abl;
            1: base = m_pc % 256;
            2: base = int'(DB);
            default: base = m_ahl;
        endcase
        case (int'(abl_op[3:2]))
            0: addend = 0;
            1: addend = int'(REG);
            2: begin base = 0; addend = int'(REG); end
`ifdef ABL_DEC_EN
            default: addend = 255;
`else
            default: addend = 0;
`endif
        endcase
        sum   = base + addend + int'(abl_ci);
        e_adl = sum % 256;
        e_co  = sum / 256;
        case (int'(abh_op))
            0: e_adh = m_abh;
            1: e_adh = (m_abh + e_co) % 256;
            2: e_adh = m_pc / 256;
            3: e_adh = (m_pc / 256 + e_co) % 256;
            4: e_adh = int'(DB);
            5: e_adh = (int'(DB) + e_co) % 256;
            6: e_adh = 0;
            default: e_adh = 1;
        endcase
        if (abh_ff) e_adh = 255;
        src       = ld_pc ? (e_adh * 256 + e_adl) : m_pc;
        e_pcl_co  = (inc_pc && (src % 256 == 255)) ? 1 : 0;
        e_pc_next = (src + int'(inc_pc)) % 65536;
    endtask

    // One clock: check combinational outputs, clock, update model, check PC
    task automatic step(input string tag);
        #1;
        model_comb();
        chk({tag, ".ad"},     {ADH, ADL},            16'(e_adh * 256 + e_adl));
        chk({tag, ".abl_co"}, 16'(abl_co),           16'(e_co));
        chk({tag, ".pcl_co"}, 16'(pcl_co),           16'(e_pcl_co));
        @(posedge clk);
        m_abl = e_adl;
        m_abh = e_adh;
        if (ld_ahl) m_ahl = int'(DB);
        m_pc  = e_pc_next;
        #1;
        chk({tag, ".pc"}, {PCH, PCL}, 16'(m_pc));
    endtask

    task automatic idle();
        abl_op = 4'b0000; abl_ci = 1'b0; abh_op = 3'b000; abh_ff = 1'b0;
        ld_ahl = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        DB = 8'h00; REG = 8'h00;
        m_abl = 0; m_abh = 0; m_ahl = 0; m_pc = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.ad", {ADH, ADL}, 16'h0000);
        chk("rst.pc", {PCH, PCL}, 16'h0000);
        reset_n = 1'b1;

        // load PC = 12FF via REG-only low byte and DB high byte
        abl_op = 4'b1000; REG = 8'hFF; abh_op = 3'b100; DB = 8'h12; ld_pc = 1'b1;
        step("ld12ff");
        // opcode fetch with low-byte wrap
        idle(); abl_op = 4'b0001; abh_op = 3'b010; ld_pc = 1'b1; inc_pc = 1'b1;
        #1;
        chk("fetch.ad", {ADH, ADL}, 16'h12FF);
        chk("fetch.pcl_co", 16'(pcl_co), 16'h0001);
        step("fetch");
        chk("fetch.pc_after", {PCH, PCL}, 16'h1300);
        idle();
        #1;
        chk("fetch.held", {ADH, ADL}, 16'h12FF);
        step("held");

        // indexed with page cross
        idle(); DB = 8'hF0; REG = 8'h20; abl_op = 4'b0110;
        #1;
        chk("idx.adl", 16'(ADL), 16'h0010);
        chk("idx.co", 16'(abl_co), 16'h0001);
        step("idx1");
        idle(); abl_op = 4'b0100; REG = 8'hF0; abh_op = 3'b101; DB = 8'h34;
        #1;
        chk("idx.adh", 16'(ADH), 16'h0035);
        step("idx2");

        // stack and vector pages
        idle(); abl_op = 4'b1000; REG = 8'hFD; abh_op = 3'b111;
        #1;
        chk("stack.ad", {ADH, ADL}, 16'h01FD);
        step("stack");
        abh_ff = 1'b1; REG = 8'hFC;
        #1;
        chk("vec.ad", {ADH, ADL}, 16'hFFFC);
        step("vec");

        // AHL latch then JMP-style load
        idle(); ld_ahl = 1'b1; DB = 8'h00;
        step("ahl");
        idle(); abl_op = 4'b0011; abh_op = 3'b100; DB = 8'hC0; ld_pc = 1'b1;
        #1;
        chk("jmp.ad", {ADH, ADL}, 16'hC000);
        step("jmp");
        chk("jmp.pc", {PCH, PCL}, 16'hC000);

        // addend code 11 from ABL = 00
        idle(); abl_op = 4'b1000; REG = 8'h00;
        step("abl0");
        idle(); abl_op = 4'b1100;
        #1;
`ifdef ABL_DEC_EN
        chk("dec.adl", 16'(ADL), 16'h00FF);
        chk("dec.co", 16'(abl_co), 16'h0000);
`else
        chk("dec.adl", 16'(ADL), 16'h0000);
        chk("dec.co", 16'(abl_co), 16'h0000);
`endif
        step("dec");

        // PC FFFF wraps to 0000
        idle(); abl_op = 4'b1000; REG = 8'hFF; abh_ff = 1'b1; ld_pc = 1'b1;
        step("ldffff");
        idle(); inc_pc = 1'b1;
        #1;
        chk("wrap.pcl_co", 16'(pcl_co), 16'h0001);
        step("wrap");
        chk("wrap.pc", {PCH, PCL}, 16'h0000);

        // randomized operations
        for (int i = 0; i < 300; i++) begin
            abl_op = 4'($urandom);
            abl_ci = 1'($urandom);
            abh_op = 3'($urandom);
            abh_ff = ($urandom_range(0, 7) == 0);
            ld_ahl = 1'($urandom);
            ld_pc  = 1'($urandom);
            inc_pc = 1'($urandom);
            DB     = 8'($urandom);
            REG    = 8'($urandom);
            step("rand");
        end

        // nonzero state, then asynchronous reset mid-cycle
        idle(); ld_ahl = 1'b1; DB = 8'h5A; abl_op = 4'b1000; REG = 8'h77;
        abh_op = 3'b111; ld_pc = 1'b1;
        step("pre_rst");
        #2;
        reset_n = 1'b0;
        idle();
        #1;
        chk("arst.ad", {ADH, ADL}, 16'h0000);
        chk("arst.pc", {PCH, PCL}, 16'h0000);
        abl_op = 4'b0011;
        #1;
        chk("arst.ahl", 16'(ADL), 16'h0000);
        m_abl = 0; m_abh = 0; m_ahl = 0; m_pc = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(); inc_pc = 1'b1;
        step("post_rst");
        chk("post_rst.pc", {PCH, PCL}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
